// File: rtl/pss_sync_ctrl_if.sv
// Correlator magnitude stream feeding pss_sync_ctrl.
// The stream has no backpressure: tvalid alone qualifies each sample.
interface pss_sync_ctrl_if #(
    parameter int IN_DW = 32
);
    logic [IN_DW-1:0] s_axis_in_tdata;
    logic             s_axis_in_tvalid;

    // Producer side (correlator or testbench driver)
    modport master (
        output s_axis_in_tdata,
        output s_axis_in_tvalid
    );

    // Consumer side (sync controller)
    modport slave (
        input  s_axis_in_tdata,
        input  s_axis_in_tvalid
    );
endinterface

// File: rtl/pss_sync_ctrl.sv
// PSS synchronisation controller.
//
// SEARCH: scans windows of WINDOW_LEN valid samples per N_ID_2 hypothesis and
// keeps the strongest sample above threshold (earliest one wins a tie). A window
// with a candidate locks onto that N_ID_2 and enters TRACK. A window without one
// moves to the next hypothesis and flushes the correlator delay line.
// TRACK: looks for the next peak only within +/-TOL samples of PERIOD after the
// last (real or virtual) peak. MISS_MAX consecutive empty windows drop back to
// SEARCH at the same hypothesis.
//
// Optional feature: define PSS_SYNC_STATS_EN to add saturating detection and
// miss counters (stat_detect_o, stat_miss_o).
module pss_sync_ctrl #(
    parameter  int IN_DW      = 32,
    parameter  int WINDOW_LEN = 9600,
    parameter  int PERIOD     = 19200,
    parameter  int TOL        = 4,
    parameter  int MISS_MAX   = 3,
    localparam int POS_DW     = $clog2((WINDOW_LEN > PERIOD + TOL + 1) ?
                                       WINDOW_LEN : PERIOD + TOL + 1)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    pss_sync_ctrl_if.slave    s_axis,
    input  logic [IN_DW-1:0]  threshold_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic [1:0]        nid2_o,
    output logic              corr_flush_no,
    output logic              detect_o,
    output logic [POS_DW-1:0] peak_pos_o,
    output logic [IN_DW-1:0]  peak_val_o,
    output logic              locked_o
`ifdef PSS_SYNC_STATS_EN
    ,
    output logic [15:0]       stat_detect_o,
    output logic [15:0]       stat_miss_o
`endif
);

    localparam int MISS_DW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    // Counter landmarks, pre-sized to the position counter width.
    localparam logic [POS_DW-1:0]  WIN_LAST   = POS_DW'(WINDOW_LEN - 1);
    localparam logic [POS_DW-1:0]  WIN_LEN    = POS_DW'(WINDOW_LEN);
    localparam logic [POS_DW-1:0]  TRK_OPEN   = POS_DW'(PERIOD - TOL);
    localparam logic [POS_DW-1:0]  TRK_LAST   = POS_DW'(PERIOD + TOL);
    localparam logic [POS_DW-1:0]  TRK_REBASE = POS_DW'(PERIOD + TOL + 1);
    localparam logic [POS_DW-1:0]  TRK_MISS_D = POS_DW'(TOL + 1);
    localparam logic [POS_DW-1:0]  POS_ONE    = POS_DW'(1);
    localparam logic [MISS_DW-1:0] MISS_LIMIT = MISS_DW'(MISS_MAX);
    localparam logic [MISS_DW-1:0] MISS_ONE   = MISS_DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [POS_DW-1:0]  cnt_q,      cnt_d;       // window index (SEARCH) or d (TRACK)
    logic [IN_DW-1:0]   max_q,      max_d;       // best candidate magnitude so far
    logic [POS_DW-1:0]  cand_pos_q, cand_pos_d;  // best candidate position so far
    logic               cand_vld_q, cand_vld_d;
    logic [MISS_DW-1:0] miss_q,     miss_d;
    logic [1:0]         nid2_q,     nid2_d;
    logic               flush_n_q,  flush_n_d;
    logic               detect_q,   detect_d;
    logic [POS_DW-1:0]  peak_pos_q, peak_pos_d;
    logic [IN_DW-1:0]   peak_val_q, peak_val_d;
    logic               miss_evt;                // TRACK window closed empty

    logic              in_vld;
    logic [IN_DW-1:0]  in_data;
    logic              in_window;
    logic              hit;
    logic              any_cand;
    logic [POS_DW-1:0] sel_pos;
    logic [IN_DW-1:0]  sel_val;
    logic [MISS_DW-1:0] miss_inc;

    assign in_vld  = s_axis.s_axis_in_tvalid;
    assign in_data = s_axis.s_axis_in_tdata;

    // In TRACK only samples at or after the window opening may become candidates.
    assign in_window = (state_q != ST_TRACK) || (cnt_q >= TRK_OPEN);

    // Strictly greater than both threshold and running max: ties keep the earliest.
    assign hit = in_vld && in_window && (in_data > threshold_i) && (in_data > max_q);

    // Candidate as it stands after including the current sample.
    assign any_cand = hit || cand_vld_q;
    assign sel_pos  = hit ? cnt_q   : cand_pos_q;
    assign sel_val  = hit ? in_data : max_q;
    assign miss_inc = miss_q + MISS_ONE;

    // Next-state and output decode for the IDLE / SEARCH / TRACK controller.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        cand_pos_d = cand_pos_q;
        cand_vld_d = cand_vld_q;
        miss_d     = miss_q;
        nid2_d     = nid2_q;
        flush_n_d  = 1'b1;
        detect_d   = 1'b0;
        peak_pos_d = peak_pos_q;
        peak_val_d = peak_val_q;
        miss_evt   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_SEARCH;
                    nid2_d     = 2'd0;
                    cnt_d      = '0;
                    max_d      = '0;
                    cand_vld_d = 1'b0;
                    miss_d     = '0;
                    flush_n_d  = 1'b0;
                end
            end

            ST_SEARCH: begin
                if (in_vld) begin
                    if (hit) begin
                        max_d      = in_data;
                        cand_pos_d = cnt_q;
                        cand_vld_d = 1'b1;
                    end
                    if (cnt_q == WIN_LAST) begin
                        max_d      = '0;
                        cand_vld_d = 1'b0;
                        if (any_cand) begin
                            // Lock: the next sample is WINDOW_LEN - pos after the peak.
                            state_d    = ST_TRACK;
                            detect_d   = 1'b1;
                            peak_pos_d = sel_pos;
                            peak_val_d = sel_val;
                            miss_d     = '0;
                            cnt_d      = WIN_LEN - sel_pos;
                        end else begin
                            // Try the next N_ID_2 hypothesis with a clean delay line.
                            nid2_d    = (nid2_q == 2'd2) ? 2'd0 : nid2_q + 2'd1;
                            cnt_d     = '0;
                            flush_n_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + POS_ONE;
                    end
                end
            end

            ST_TRACK: begin
                if (in_vld) begin
                    if (hit) begin
                        max_d      = in_data;
                        cand_pos_d = cnt_q;
                        cand_vld_d = 1'b1;
                    end
                    if (cnt_q == TRK_LAST) begin
                        max_d      = '0;
                        cand_vld_d = 1'b0;
                        if (any_cand) begin
                            // Re-anchor d on the detected peak.
                            detect_d   = 1'b1;
                            peak_pos_d = sel_pos;
                            peak_val_d = sel_val;
                            miss_d     = '0;
                            cnt_d      = TRK_REBASE - sel_pos;
                        end else begin
                            miss_evt = 1'b1;
                            if (miss_inc == MISS_LIMIT) begin
                                // Lost lock: rescan the same hypothesis from scratch.
                                state_d   = ST_SEARCH;
                                cnt_d     = '0;
                                miss_d    = '0;
                                flush_n_d = 1'b0;
                            end else begin
                                // Virtual peak at d = PERIOD.
                                miss_d = miss_inc;
                                cnt_d  = TRK_MISS_D;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + POS_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // stop_i wins over everything, including a window close in the same cycle.
        if (stop_i) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            max_d      = '0;
            cand_vld_d = 1'b0;
            miss_d     = '0;
            nid2_d     = nid2_q;
            flush_n_d  = 1'b1;
            detect_d   = 1'b0;
            peak_pos_d = peak_pos_q;
            peak_val_d = peak_val_q;
            miss_evt   = 1'b0;
        end
    end

    // State, counters, candidate and registered outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            max_q      <= '0;
            cand_pos_q <= '0;
            cand_vld_q <= 1'b0;
            miss_q     <= '0;
            nid2_q     <= 2'd0;
            flush_n_q  <= 1'b1;
            detect_q   <= 1'b0;
            peak_pos_q <= '0;
            peak_val_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            cand_pos_q <= cand_pos_d;
            cand_vld_q <= cand_vld_d;
            miss_q     <= miss_d;
            nid2_q     <= nid2_d;
            flush_n_q  <= flush_n_d;
            detect_q   <= detect_d;
            peak_pos_q <= peak_pos_d;
            peak_val_q <= peak_val_d;
        end
    end

    assign nid2_o        = nid2_q;
    assign corr_flush_no = flush_n_q;
    assign detect_o      = detect_q;
    assign peak_pos_o    = peak_pos_q;
    assign peak_val_o    = peak_val_q;
    assign locked_o      = (state_q == ST_TRACK);

`ifdef PSS_SYNC_STATS_EN
    logic        start_accept;
    logic [15:0] stat_detect_q;
    logic [15:0] stat_miss_q;

    assign start_accept = (state_q == ST_IDLE) && start_i && !stop_i;

    // Saturating event counters, restarted with every accepted start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stat_detect_q <= '0;
            stat_miss_q   <= '0;
        end else if (start_accept) begin
            stat_detect_q <= '0;
            stat_miss_q   <= '0;
        end else begin
            if (detect_d && (stat_detect_q != 16'hFFFF)) begin
                stat_detect_q <= stat_detect_q + 16'd1;
            end
            if (miss_evt && (stat_miss_q != 16'hFFFF)) begin
                stat_miss_q <= stat_miss_q + 16'd1;
            end
        end
    end

    assign stat_detect_o = stat_detect_q;
    assign stat_miss_o   = stat_miss_q;
`endif

endmodule

// File: tb/tb_pss_sync_ctrl.sv
// Directed testbench for pss_sync_ctrl with WINDOW_LEN=16, PERIOD=32, TOL=2,
// MISS_MAX=3 and threshold 100. Background samples are 50 (below threshold).
module tb_pss_sync_ctrl;

    localparam int IN_DW  = 32;
    localparam int POS_DW = 6;
    localparam logic [IN_DW-1:0] BG = 32'd50;

    logic              clk_i;
    logic              reset_ni;
    logic [IN_DW-1:0]  threshold_i;
    logic              start_i;
    logic              stop_i;
    logic [1:0]        nid2_o;
    logic              corr_flush_no;
    logic              detect_o;
    logic [POS_DW-1:0] peak_pos_o;
    logic [IN_DW-1:0]  peak_val_o;
    logic              locked_o;

    int n_checks = 0;
    int n_errors = 0;

    pss_sync_ctrl_if #(.IN_DW(IN_DW)) bus ();

    pss_sync_ctrl #(
        .IN_DW      (IN_DW),
        .WINDOW_LEN (16),
        .PERIOD     (32),
        .TOL        (2),
        .MISS_MAX   (3)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .s_axis        (bus),
        .threshold_i   (threshold_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .nid2_o        (nid2_o),
        .corr_flush_no (corr_flush_no),
        .detect_o      (detect_o),
        .peak_pos_o    (peak_pos_o),
        .peak_val_o    (peak_val_o),
        .locked_o      (locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int   idx_a;
        int   val_a;
        int   idx_b;
        int   val_b;
        logic exp_det;
        int   exp_pos;
        int   exp_val;
        int   exp_nid2;
        logic exp_lock;
    } scen_t;

    scen_t scen [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given sample; outputs are sampled 1 ns after the edge.
    task automatic send(input logic v, input logic [IN_DW-1:0] d);
        bus.s_axis_in_tvalid = v;
        bus.s_axis_in_tdata  = d;
        @(posedge clk_i);
        #1;
    endtask

    // One clock carrying a start and/or stop pulse with no valid sample.
    task automatic cmd(input logic st, input logic sp);
        start_i = st;
        stop_i  = sp;
        send(1'b0, '0);
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    // Valid samples for positions first..last, background except up to two peaks.
    task automatic feed(input int first, input int last,
                        input int ia, input int va, input int ib, input int vb);
        for (int i = first; i <= last; i++) begin
            if (i == ia)      send(1'b1, IN_DW'(va));
            else if (i == ib) send(1'b1, IN_DW'(vb));
            else              send(1'b1, BG);
        end
    endtask

    initial begin
        int cur_pos;
        int cur_val;

        scen[0] = '{5,  300, 9,  300, 1'b1, 5,  300, 0, 1'b1};  // tie keeps earliest
        scen[1] = '{2,  200, 11, 250, 1'b1, 11, 250, 0, 1'b1};  // later larger wins
        scen[2] = '{4,  100, -1, 0,   1'b0, 0,  0,   1, 1'b0};  // equal to threshold
        scen[3] = '{0,  150, -1, 0,   1'b1, 0,  150, 0, 1'b1};  // first index
        scen[4] = '{15, 200, 3,  180, 1'b1, 15, 200, 0, 1'b1};  // closing sample
        scen[5] = '{6,  400, 7,  399, 1'b1, 6,  400, 0, 1'b1};  // later smaller loses
        scen[6] = '{8,  101, -1, 0,   1'b1, 8,  101, 0, 1'b1};  // just above threshold

        reset_ni             = 1'b0;
        threshold_i          = 32'd100;
        start_i              = 1'b0;
        stop_i               = 1'b0;
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tdata  = '0;

        // ---- reset state
        #12;
        check("rst_nid2",   nid2_o,        0);
        check("rst_flush",  corr_flush_no, 1);
        check("rst_detect", detect_o,      0);
        check("rst_pos",    peak_pos_o,    0);
        check("rst_val",    peak_val_o,    0);
        check("rst_locked", locked_o,      0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // ---- hypothesis stepping with no candidate
        cmd(1'b1, 1'b0);
        check("start_flush", corr_flush_no, 0);
        check("start_nid2",  nid2_o,        0);
        feed(0, 14, -1, 0, -1, 0);
        check("w0_flush_mid", corr_flush_no, 1);
        check("w0_nid2_mid",  nid2_o,        0);
        feed(15, 15, -1, 0, -1, 0);
        check("w0_nid2",   nid2_o,        1);
        check("w0_flush",  corr_flush_no, 0);
        check("w0_detect", detect_o,      0);
        send(1'b0, '0);
        check("w0_flush_1cyc", corr_flush_no, 1);
        feed(0, 15, -1, 0, -1, 0);
        check("w1_nid2", nid2_o, 2);
        feed(0, 15, -1, 0, -1, 0);
        check("w2_nid2_wrap", nid2_o,   0);
        check("w2_locked",    locked_o, 0);

        // ---- table of single-window searches
        cur_pos = 0;
        cur_val = 0;
        for (int e = 0; e < 7; e++) begin
            cmd(1'b0, 1'b1);
            cmd(1'b1, 1'b0);
            feed(0, 14, scen[e].idx_a, scen[e].val_a, scen[e].idx_b, scen[e].val_b);
            check($sformatf("scen%0d_pre_detect", e), detect_o, 0);
            feed(15, 15, scen[e].idx_a, scen[e].val_a, scen[e].idx_b, scen[e].val_b);
            if (scen[e].exp_det) begin
                cur_pos = scen[e].exp_pos;
                cur_val = scen[e].exp_val;
            end
            check($sformatf("scen%0d_detect", e), detect_o,      scen[e].exp_det);
            check($sformatf("scen%0d_pos", e),    peak_pos_o,    cur_pos);
            check($sformatf("scen%0d_val", e),    peak_val_o,    cur_val);
            check($sformatf("scen%0d_locked", e), locked_o,      scen[e].exp_lock);
            check($sformatf("scen%0d_nid2", e),   nid2_o,        scen[e].exp_nid2);
            check($sformatf("scen%0d_flush", e),  corr_flush_no, scen[e].exp_det);
            send(1'b0, '0);
            check($sformatf("scen%0d_det_1cyc", e), detect_o, 0);
        end

        // ---- tracking: lock at nid2=1, then follow peaks by relative distance d
        cmd(1'b0, 1'b1);
        cmd(1'b1, 1'b0);
        feed(0, 15, -1, 0, -1, 0);
        feed(0, 15, 5, 300, 9, 300);
        check("lock_detect", detect_o,   1);
        check("lock_pos",    peak_pos_o, 5);
        check("lock_nid2",   nid2_o,     1);
        // first sample after lock has d = 16 - 5 = 11; out-of-window 900 at d=20
        feed(11, 33, 33, 400, 20, 900);
        check("trk1_pre_detect", detect_o, 0);
        feed(34, 34, -1, 0, -1, 0);
        check("trk1_detect", detect_o,   1);
        check("trk1_pos",    peak_pos_o, 33);
        check("trk1_val",    peak_val_o, 400);
        check("trk1_locked", locked_o,   1);
        // next d = 35 - 33 = 2; 900 at d=29 just outside, 450 at d=30 on the edge
        feed(2, 34, 29, 900, 30, 450);
        check("trk2_detect", detect_o,   1);
        check("trk2_pos",    peak_pos_o, 30);
        check("trk2_val",    peak_val_o, 450);
        // next d = 35 - 30 = 5; peak on the closing sample d=34
        feed(5, 34, 34, 600, -1, 0);
        check("trk3_detect", detect_o,   1);
        check("trk3_pos",    peak_pos_o, 34);
        check("trk3_val",    peak_val_o, 600);

        // ---- three empty windows: next d = 1, then d = TOL+1 = 3 after each miss
        feed(1, 34, -1, 0, -1, 0);
        check("miss1_detect", detect_o, 0);
        check("miss1_locked", locked_o, 1);
        check("miss1_pos",    peak_pos_o, 34);
        feed(3, 34, -1, 0, -1, 0);
        check("miss2_locked", locked_o, 1);
        feed(3, 33, -1, 0, -1, 0);
        check("miss3_pre_locked", locked_o, 1);
        feed(34, 34, -1, 0, -1, 0);
        check("miss3_locked", locked_o,      0);
        check("miss3_nid2",   nid2_o,        1);
        check("miss3_flush",  corr_flush_no, 0);
        check("miss3_detect", detect_o,      0);
        send(1'b0, '0);
        check("miss3_flush_1cyc", corr_flush_no, 1);
        feed(0, 15, 3, 250, -1, 0);
        check("relock_detect", detect_o,   1);
        check("relock_pos",    peak_pos_o, 3);
        check("relock_nid2",   nid2_o,     1);

        // ---- tvalid toggling: gaps carry a large value that must be ignored
        cmd(1'b0, 1'b1);
        check("stop_locked", locked_o, 0);
        cmd(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, (i == 5 || i == 9) ? 32'd300 : BG);
            if (i == 15) begin
                check("stall_detect", detect_o,   1);
                check("stall_pos",    peak_pos_o, 5);
                check("stall_val",    peak_val_o, 300);
                check("stall_locked", locked_o,   1);
            end else if (i == 14) begin
                check("stall_pre_detect", detect_o, 0);
            end
            send(1'b0, 32'd999);
        end
        check("stall_gap_detect", detect_o, 0);
        check("stall_gap_locked", locked_o, 1);

        // ---- stop mid-TRACK with a valid sample present
        stop_i = 1'b1;
        send(1'b1, BG);
        stop_i = 1'b0;
        check("stop_trk_locked", locked_o, 0);
        check("stop_trk_detect", detect_o, 0);

        // ---- start and stop together in IDLE stay in IDLE
        cmd(1'b1, 1'b1);
        check("startstop_flush",  corr_flush_no, 1);
        feed(0, 15, 2, 300, -1, 0);
        check("startstop_detect", detect_o, 0);
        check("startstop_locked", locked_o, 0);

        // ---- stop coinciding with a closing window that has a candidate
        cmd(1'b1, 1'b0);
        feed(0, 14, 7, 300, -1, 0);
        stop_i = 1'b1;
        send(1'b1, BG);
        stop_i = 1'b0;
        check("stopclose_detect", detect_o, 0);
        check("stopclose_locked", locked_o, 0);

        // ---- start in SEARCH is ignored (no restart, no flush)
        cmd(1'b1, 1'b0);
        feed(0, 7, -1, 0, -1, 0);
        cmd(1'b1, 1'b0);
        check("ign_start_flush", corr_flush_no, 1);
        feed(8, 15, 12, 300, -1, 0);
        check("ign_start_detect", detect_o,   1);
        check("ign_start_pos",    peak_pos_o, 12);

        // ---- asynchronous reset mid-SEARCH with a pending candidate
        cmd(1'b0, 1'b1);
        cmd(1'b1, 1'b0);
        feed(0, 15, -1, 0, -1, 0);
        feed(0, 6, 3, 700, -1, 0);
        #2;
        reset_ni = 1'b0;
        #1;
        check("arst_nid2",   nid2_o,        0);
        check("arst_flush",  corr_flush_no, 1);
        check("arst_detect", detect_o,      0);
        check("arst_pos",    peak_pos_o,    0);
        check("arst_val",    peak_val_o,    0);
        check("arst_locked", locked_o,      0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        feed(0, 19, 5, 300, -1, 0);
        check("arst_idle_detect", detect_o, 0);
        check("arst_idle_nid2",   nid2_o,   0);
        cmd(1'b1, 1'b0);
        feed(0, 15, -1, 0, -1, 0);
        check("arst_disc_detect", detect_o, 0);
        check("arst_disc_nid2",   nid2_o,   1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pss_sync_ctrl.md
PSS_SYNC_CTRL -- requirements
Module: pss_sync_ctrl

Interface
REQ-001 SHALL have parameter IN_DW, default 32: width of correlator magnitude input and threshold.
REQ-002 SHALL have parameter WINDOW_LEN, default 9600: valid samples searched per N_ID_2 hypothesis.
REQ-003 SHALL have parameter PERIOD, default 19200: expected valid-sample distance between consecutive PSS peaks.
REQ-004 SHALL have parameter TOL, default 4: half-width of tracking window in samples; PERIOD > 2*TOL+1.
REQ-005 SHALL have parameter MISS_MAX, default 3: consecutive tracking misses before returning to search.
REQ-006 SHALL have localparam POS_DW = $clog2(max(WINDOW_LEN, PERIOD+TOL+1)).
REQ-007 clk_i  input  1  clock; every register samples on its rising edge.
REQ-008 reset_ni  input  1  asynchronous, active-low reset.
REQ-009 s_axis_in_tdata  input  IN_DW  unsigned correlator magnitude sample.
REQ-010 s_axis_in_tvalid  input  1  sample qualifier; no backpressure.
REQ-011 threshold_i  input  IN_DW  detection threshold, sampled each valid cycle.
REQ-012 start_i / stop_i  input  1 each  single-cycle command pulses.
REQ-013 nid2_o  output  2  N_ID_2 hypothesis selecting correlator taps, range 0..2.
REQ-014 corr_flush_no  output  1  active-low, one-cycle correlator delay-line flush request.
REQ-015 detect_o  output  1  one-cycle detection pulse.
REQ-016 peak_pos_o  output  POS_DW  position of detected peak (REQ-025/REQ-029).
REQ-017 peak_val_o  output  IN_DW  magnitude of detected peak.
REQ-018 locked_o  output  1  high while in TRACK.

Function
REQ-019 States SHALL be IDLE, SEARCH, TRACK; only valid samples (tvalid=1) advance counters or compare; tvalid=0 holds all state.
REQ-020 stop_i SHALL force IDLE on next edge from any state, overriding all other events incl. simultaneous start_i or window close.
REQ-021 IDLE: start_i -> SEARCH with nid2_o=0, window counter 0, max cleared, corr_flush_no low one cycle.
REQ-022 SEARCH: candidate updated when sample > threshold_i and > current max (strict; ties keep earliest).
REQ-023 SEARCH window closes on valid sample with window index WINDOW_LEN-1 (that sample included in compare).
REQ-024 Close with no candidate: nid2_o advances 0->1->2->0 (wrap), counter cleared, corr_flush_no low one cycle, stay SEARCH.
REQ-025 Close with candidate: -> TRACK, detect_o pulses, peak_pos_o = window index of candidate, peak_val_o = its value, nid2_o held.
REQ-026 TRACK: d = valid samples since last (actual or virtual) peak; peak has d=0; window d in [PERIOD-TOL, PERIOD+TOL].
REQ-027 Entering TRACK: next valid sample gets d = WINDOW_LEN - candidate index.
REQ-028 TRACK compare rule as REQ-022, applied only inside window; closes at d=PERIOD+TOL.
REQ-029 Close with candidate at d=p: detect_o pulses, peak_pos_o=p, peak_val_o updated, miss counter cleared, next sample d = PERIOD+TOL+1-p.
REQ-030 Close without candidate: miss counter +1, virtual peak at d=PERIOD, next sample d=TOL+1; no detect_o.
REQ-031 Miss counter reaching MISS_MAX: -> SEARCH at current nid2_o, window cleared, corr_flush_no low one cycle.
REQ-032 detect_o, peak_pos_o, peak_val_o SHALL be registered: update one cycle after the closing sample; pos/val hold between detections.
REQ-033 start_i while in SEARCH or TRACK SHALL be ignored.

Reset
REQ-034 reset_ni low SHALL asynchronously force IDLE, nid2_o=0, corr_flush_no=1, detect_o=0, peak_pos_o=0, peak_val_o=0, locked_o=0, all counters 0.
REQ-035 Reset mid-window SHALL discard candidate; after release only start_i leaves IDLE.

Configuration
REQ-036 Macro PSS_SYNC_STATS_EN defined: add outputs stat_detect_o[15:0], stat_miss_o[15:0], saturating counts of detect_o pulses and TRACK misses, cleared by reset and start_i.
REQ-037 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification (WINDOW_LEN=16, PERIOD=32, TOL=2, MISS_MAX=3, threshold 100)
REQ-038 start, 16 samples all 50 -> no detect, nid2_o 0->1, corr_flush_no low 1 cycle; 48 such samples -> nid2_o wraps to 0.
REQ-039 start, sample idx 5=300, idx 9=300 -> detect_o 1 cycle after idx 15, peak_pos_o=5, peak_val_o=300, locked_o=1.
REQ-040 TRACK, peak 400 at d=33 -> detect_o, peak_pos_o=33; next peak expected at d=32 from it.
REQ-041 TRACK, three windows below threshold -> third close returns SEARCH, locked_o=0, nid2_o unchanged, flush pulse.
REQ-042 tvalid toggled 50% during REQ-039 stimulus -> identical outputs, only delayed; stop_i mid-TRACK -> IDLE next edge.
REQ-043 reset_ni asserted asynchronously mid-SEARCH -> all outputs at reset values before next clock edge.
